// File: rtl/i2c_slave_regs.sv
// I2C target with a byte-wide register file, accessed EEPROM-style: a word-pointer
// write, then sequential writes or reads with pointer auto-increment. SDA is open-drain.
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         DEPTH      = 16,
  parameter int         PTR_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  output logic             busy,
  output logic             wr_pulse,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data
);
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WORD, S_WR_DATA, S_RD_LOAD, S_RD_DATA, S_WAIT
  } state_t;

  localparam logic [PTR_W-1:0] PTR_ONE = 1;

  state_t           state, state_nxt;
  logic [2:0]       scl_sync, sda_sync;
  logic             scl, scl_d, sda, sda_d;
  logic             scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]       regs [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [7:0]       shift;
  logic [3:0]       bit_cnt;
  logic             ack_phase;
  logic             rx_state, rx_shift, byte_done, addr_match;
  logic             ack_start, ack_end, tx_fall, master_ack_sample;
  logic [7:0]       byte_in;

  // Two synchronizer flops plus a third for edge detection; idle bus level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 3'b111;
      sda_sync <= 3'b111;
    end else begin
      scl_sync <= {scl_sync[1:0], scl_in};
      sda_sync <= {sda_sync[1:0], sda_in};
    end
  end

  assign scl       = scl_sync[1];
  assign scl_d     = scl_sync[2];
  assign sda       = sda_sync[1];
  assign sda_d     = sda_sync[2];
  assign scl_rise  = scl & ~scl_d;
  assign scl_fall  = ~scl & scl_d;
  assign start_det = scl & scl_d & sda_d & ~sda;
  assign stop_det  = scl & scl_d & ~sda_d & sda;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Bit-slot decode shared by the next-state logic and the datapath
  always_comb begin
    rx_state          = (state == S_ADDR) || (state == S_WORD) || (state == S_WR_DATA);
    rx_shift          = rx_state && scl_rise && (bit_cnt < 4'd8);
    byte_done         = rx_shift && (bit_cnt == 4'd7);
    byte_in           = {shift[6:0], sda};
    addr_match        = (byte_in[7:1] == SLAVE_ADDR);
    ack_start         = scl_fall && !ack_phase && (bit_cnt == 4'd8) &&
                        ((state == S_WORD) || (state == S_WR_DATA) || (state == S_RD_LOAD));
    ack_end           = scl_fall && ack_phase;
    tx_fall           = (state == S_RD_DATA) && scl_fall;
    master_ack_sample = (state == S_RD_DATA) && scl_rise && (bit_cnt == 4'd9);
  end

  // Next-state logic; state moves on the 8th data rise so the ACK slot belongs to the new state
  always_comb begin
    state_nxt = state;
    if (stop_det) begin
      state_nxt = S_IDLE;
    end else if (start_det) begin
      state_nxt = S_ADDR;
    end else begin
      case (state)
        S_ADDR:    if (byte_done) state_nxt = !addr_match ? S_WAIT :
                                              (byte_in[0] ? S_RD_LOAD : S_WORD);
        S_WORD:    if (byte_done) state_nxt = S_WR_DATA;
        S_RD_LOAD: if (ack_end) state_nxt = S_RD_DATA;
        S_RD_DATA: if (master_ack_sample) state_nxt = sda ? S_WAIT : S_RD_LOAD;
        default:   state_nxt = state;
      endcase
    end
  end

  // Datapath: shifter, pointer, register file, SDA drive and strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_pulse  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      ptr       <= '0;
      shift     <= '0;
      bit_cnt   <= '0;
      ack_phase <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
    end else begin
      wr_pulse <= 1'b0;
      if (stop_det) begin
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
      end else if (start_det) begin
        sda_oe    <= 1'b0;
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
      end else begin
        if (rx_shift) begin
          shift   <= byte_in;
          bit_cnt <= bit_cnt + 4'd1;
        end
        if (byte_done) begin
          case (state)
            S_ADDR: busy <= addr_match;
            S_WORD: ptr  <= byte_in[PTR_W-1:0];
            S_WR_DATA: begin
              regs[ptr] <= byte_in;
              wr_pulse  <= 1'b1;
              wr_addr   <= ptr;
              wr_data   <= byte_in;
              ptr       <= ptr + PTR_ONE;
            end
            default: ;
          endcase
        end
        if (ack_start) begin
          sda_oe    <= 1'b1;
          ack_phase <= 1'b1;
        end
        if (ack_end) begin
          ack_phase <= 1'b0;
          if (state == S_RD_LOAD) begin
            // Loading and driving the MSB share the fall that closes the ACK slot
            sda_oe  <= ~regs[ptr][7];
            shift   <= {regs[ptr][6:0], 1'b0};
            ptr     <= ptr + PTR_ONE;
            bit_cnt <= 4'd1;
          end else begin
            sda_oe  <= 1'b0;
            bit_cnt <= '0;
          end
        end
        if (tx_fall) begin
          if (bit_cnt < 4'd8) begin
            sda_oe  <= ~shift[7];
            shift   <= {shift[6:0], 1'b0};
            bit_cnt <= bit_cnt + 4'd1;
          end else if (bit_cnt == 4'd8) begin
            sda_oe  <= 1'b0;
            bit_cnt <= 4'd9;
          end
        end
        if (master_ack_sample) begin
          if (sda) busy      <= 1'b0;
          else     ack_phase <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: a bit-banged I2C master drives the bus; ACKs, read
// bytes and write strobes are checked against expected queues filled by the stimulus.
module tb_i2c_slave_regs;
  localparam int Q = 40;

  logic       clk, rst_n, scl, sda_m;
  logic       sda_oe, busy, wr_pulse;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       sda_bus;

  int tests = 0;
  int fails = 0;

  logic [11:0] wr_exp_q[$];
  logic [7:0]  rd_exp_q[$];
  logic        ack_exp_q[$];

  logic [7:0] rd_obs;
  logic       ack_obs;
  event       rd_ev, ack_ev;
  logic       watch_oe, oe_seen;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_regs #(.SLAVE_ADDR(7'h50), .DEPTH(16), .PTR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda_bus),
    .sda_oe(sda_oe), .busy(busy), .wr_pulse(wr_pulse),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic write_bit(input logic b);
    sda_m = b;
    #Q scl = 1'b1;
    #(2*Q) scl = 1'b0;
    #Q;
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1;
    #Q scl = 1'b1;
    #Q b = sda_bus;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic bus_start();
    sda_m = 1'b1;
    #Q scl = 1'b1;
    #(2*Q) sda_m = 1'b0;
    #(2*Q) scl = 1'b0;
    #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    #Q scl = 1'b1;
    #(2*Q) sda_m = 1'b1;
    #(2*Q);
  endtask

  task automatic send(input logic [7:0] d, input logic exp_ack);
    logic b;
    ack_exp_q.push_back(exp_ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack_obs = ~b;
    ->ack_ev;
  endtask

  task automatic recv(input logic [7:0] exp_d, input logic master_ack);
    logic [7:0] d;
    logic b;
    rd_exp_q.push_back(exp_d);
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    rd_obs = d;
    ->rd_ev;
    write_bit(~master_ack);
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (rst_n && wr_pulse) begin
      if (wr_exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL wr_unexpected: got addr %0h data %0h expected no write", wr_addr, wr_data);
      end else begin
        check("wr_pulse", {wr_addr, wr_data}, wr_exp_q.pop_front());
      end
    end
  end

  always begin : ack_mon
    @(ack_ev);
    if (ack_exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL ack_unexpected: got %0b expected none", ack_obs);
    end else begin
      check("ack", ack_obs, ack_exp_q.pop_front());
    end
  end

  always begin : rd_mon
    @(rd_ev);
    if (rd_exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL rd_unexpected: got %0h expected none", rd_obs);
    end else begin
      check("rd_byte", rd_obs, rd_exp_q.pop_front());
    end
  end

  always @(posedge clk) if (watch_oe && sda_oe) oe_seen <= 1'b1;

  initial begin
    rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1;
    watch_oe = 1'b0; oe_seen = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_pulse", wr_pulse, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    rst_n = 1'b1;
    settle();

    // Single write
    bus_start();
    wr_exp_q.push_back({4'd3, 8'h5A});
    send(8'hA0, 1'b1);
    send(8'h03, 1'b1);
    send(8'h5A, 1'b1);
    check("t1_busy_active", busy, 1);
    bus_stop();
    settle();
    check("t1_busy_after_stop", busy, 0);
    check("t1_reg3", dut.regs[3], 8'h5A);

    // Sequential write with pointer wrap
    bus_start();
    wr_exp_q.push_back({4'd15, 8'h11});
    wr_exp_q.push_back({4'd0, 8'h22});
    send(8'hA0, 1'b1);
    send(8'h0F, 1'b1);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    bus_stop();
    settle();
    check("t2_ptr", dut.ptr, 1);

    // Random read with repeated START, master NACK
    bus_start();
    send(8'hA0, 1'b1);
    send(8'h03, 1'b1);
    bus_start();
    send(8'hA1, 1'b1);
    recv(8'h5A, 1'b0);
    settle();
    check("t3_sda_oe_after_nack", sda_oe, 0);
    check("t3_busy_after_nack", busy, 0);
    check("t3_ptr", dut.ptr, 4);
    bus_stop();
    settle();

    // Sequential read from pointer 14 through the wrap
    bus_start();
    wr_exp_q.push_back({4'd14, 8'hC3});
    send(8'hA0, 1'b1);
    send(8'h0E, 1'b1);
    send(8'hC3, 1'b1);
    bus_stop();
    bus_start();
    send(8'hA0, 1'b1);
    send(8'h0E, 1'b1);
    bus_stop();
    bus_start();
    send(8'hA1, 1'b1);
    recv(8'hC3, 1'b1);
    recv(8'h11, 1'b0);
    bus_stop();
    settle();
    check("t4_ptr_wrap", dut.ptr, 0);
    check("t4_busy", busy, 0);

    // Address mismatch: no ACK, no write
    bus_start();
    watch_oe = 1'b1;
    send(8'hA2, 1'b0);
    send(8'h77, 1'b0);
    watch_oe = 1'b0;
    check("t5_busy_mismatch", busy, 0);
    bus_stop();
    settle();
    check("t5_oe_never", oe_seen, 0);

    // Aborted byte: partial data then STOP
    bus_start();
    send(8'hA0, 1'b1);
    send(8'h01, 1'b1);
    for (int i = 0; i < 4; i++) write_bit(i[0]);
    bus_stop();
    settle();
    check("t5_state_idle", int'(dut.state), 0);
    check("t5_ptr", dut.ptr, 1);
    check("t5_busy_abort", busy, 0);

    // Reset mid-read while the target pulls SDA low (reg[1] is 0x00)
    bus_start();
    send(8'hA1, 1'b1);
    check("t6_pre_sda_oe", sda_oe, 1);
    check("t6_pre_state", int'(dut.state), 5);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("t6_async_release", sda_oe, 0);
    scl = 1'b1; sda_m = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_busy_rst", busy, 0);
    rst_n = 1'b1;
    settle();
    bus_start();
    send(8'hA0, 1'b1);
    send(8'h03, 1'b1);
    bus_start();
    send(8'hA1, 1'b1);
    recv(8'h00, 1'b0);
    bus_stop();
    settle();

    check("end_wr_q_empty", wr_exp_q.size(), 0);
    check("end_rd_q_empty", rd_exp_q.size(), 0);
    check("end_ack_q_empty", ack_exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/i2c_slave_regs.md
Name: i2c_slave_regs

Overview:
- Synthesizable I2C target (responder) for the opposite end of the bus from i2c_master_top.
- Holds a small byte-wide register file that the master accesses EEPROM-style: a word-pointer write, then sequential writes or reads with auto-increment.
- Oversamples SCL/SDA on the system clock and drives SDA open-drain through an output-enable.
- Used as a synthesizable bus partner and as an on-chip register bank reachable over I2C.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit bus address this target acknowledges.
DEPTH, 16, number of byte registers; power of two, 2..256.
PTR_W, 4, pointer width, equal to log2(DEPTH).

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
scl_in  input  1  SCL bus level, asynchronous.
sda_in  input  1  SDA bus level, asynchronous.
sda_oe  output  1  1 pulls SDA low; 0 releases SDA (pull-up).
busy  output  1  high from an address match until STOP, NACKed address, or master NACK.
wr_pulse  output  1  one-clk strobe for each committed data byte.
wr_addr  output  PTR_W  register index of the committed byte, valid with wr_pulse.
wr_data  output  8  committed byte, valid with wr_pulse.

Behaviour:
- Reset (async, rst_n=0): sda_oe=0, busy=0, wr_pulse=0, wr_addr=0, wr_data=0, pointer=0, all registers=8'h00, state IDLE.
- Synchronizers:
  - scl_in and sda_in each pass through 2 flops, plus a third flop for edge detection.
  - Event latency from pin to detection is 3 clk.
  - SCL high and SCL low must each last at least 4 clk.
- Bus events, on synchronized signals:
  - START = SDA falls while SCL is high.
  - STOP = SDA rises while SCL is high.
  - Data is sampled on the SCL rising edge.
  - sda_oe changes only on the SCL falling edge, or on STOP/START/reset.
- START or repeated START in any state: go to ADDR, bit counter=0, sda_oe=0.
- STOP in any state: go to IDLE, sda_oe=0, busy=0. A partial byte is discarded.
- States:
  - IDLE: wait for START.
  - ADDR: shift in 8 bits, MSB first.
    - If bits[7:1]==SLAVE_ADDR, assert sda_oe on the next SCL fall (ACK) and set busy. R/W=0 goes to WORD; R/W=1 goes to RD_LOAD.
    - On mismatch, sda_oe stays 0 and the state goes to WAIT.
  - WORD: shift in 8 bits. Pointer <= byte[PTR_W-1:0]. Drive ACK, then go to WR_DATA.
  - WR_DATA: shift in 8 bits.
    - On the 8th rising edge: reg[pointer] <= byte; wr_pulse=1 for one clk with wr_addr=pointer and wr_data=byte; pointer <= pointer+1 modulo DEPTH.
    - Drive ACK, then stay in WR_DATA.
  - ACK timing: sda_oe=1 from the SCL fall after bit 8 until the next SCL fall. It is then released, except in RD_LOAD, where the MSB is driven.
  - RD_LOAD: on the SCL fall that ends the ACK slot, shift register <= reg[pointer] and pointer <= pointer+1 modulo DEPTH. Go to RD_DATA.
  - RD_DATA:
    - On each SCL fall, sda_oe = ~shift[7] and shift left; 8 bits are driven MSB first.
    - After the 8th bit's SCL fall, sda_oe=0 (release for the master's ACK). Sample SDA on the 9th rising edge.
    - If SDA is 0 (ACK), go to RD_LOAD for the next byte.
    - If SDA is 1 (NACK), busy=0 and go to WAIT.
  - WAIT: sda_oe=0. Ignore everything until START or STOP.
- Boundary conditions:
  - A read without a preceding word write uses the current pointer (current-address read).
  - Simultaneous wr_pulse and STOP cannot occur, because they fall in different SCL phases.
  - Reset during any transfer releases SDA immediately.

Test Plan:
- Single write: START, 0xA0, 0x03, 0x5A, STOP. Required: ACK on all three bytes; one wr_pulse with wr_addr=3, wr_data=0x5A; reg[3]=0x5A; busy=0 after STOP.
- Sequential write with wrap: START, 0xA0, 0x0F, 0x11, 0x22, STOP. Required: reg[15]=0x11, reg[0]=0x22; two wr_pulse with addresses 15 then 0.
- Random read with repeated START: after test 1, START, 0xA0, 0x03, Sr, 0xA1.
  - The slave drives 0x5A.
  - The master NACKs, then STOP.
  - Required: sda_oe=0 after the NACK, pointer=4.
- Sequential read: START, 0xA1 with pointer=14 and reg[14]=0xC3, reg[15]=0x11. Master ACKs, then NACKs. Required: bytes 0xC3 then 0x11 appear on the bus; pointer wraps to 0.
- Address mismatch and aborted byte:
  - START, 0xA2, then a data byte. Required: sda_oe never asserts; no wr_pulse.
  - START, 0xA0, 0x01, 4 data bits, STOP. Required: no wr_pulse; state IDLE.
- Reset mid-read: assert rst_n=0 while sda_oe=1 during RD_DATA. Required: sda_oe=0 without a clock edge; registers read 0x00 afterwards.
